alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU in the integer core.
- Accepts decoded instructions from decode over a valid/ready handshake.
- Resolves operand forwarding from EX and WB and detects load-use hazards.
- Registers alu_a/alu_b/alu_control plus the destination metadata consumed by the ALU and the EX/MEM stage.
- Supports pipeline flush and keeps a saturating stall counter for performance monitoring.

Parameters:
N, 32, datapath width (ALU operand width)
REGW, 5, register-address width
CNTW, 32, stall-counter width

Ports:
clk  in  1  core clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  decode holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
in_rs1_addr, in_rs2_addr  in  REGW  source register addresses
in_rs1_data, in_rs2_data  in  N  register-file read data
in_imm  in  N  sign-extended immediate
in_use_imm  in  1  1: operand b = in_imm
in_alu_control  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
in_rd_addr  in  REGW  destination register
in_reg_write  in  1  instruction writes rd
in_is_load  in  1  instruction is a load (rd valid only after MEM)
flush  in  1  kill stage contents and block capture
ex_rd_addr, ex_reg_write, ex_is_load  in  REGW/1/1  instruction currently in EX
ex_result  in  N  ALU result of EX instruction (combinational)
wb_rd_addr, wb_reg_write  in  REGW/1  writeback source
wb_data  in  N  writeback data
out_valid  out  1  stage register holds valid instruction
out_ready  in  1  EX accepts stage contents
alu_a, alu_b  out  N  registered ALU operands
alu_control  out  3  registered ALU op
out_rd_addr, out_reg_write, out_is_load  out  REGW/1/1  registered metadata
illegal_op  out  1  sticky: an illegal alu_control was captured
stall_cnt  out  CNTW  saturating count of load-use stall cycles

Behaviour:
- Reset (rstn=0, asynchronous): all outputs and registers are 0, including out_valid, alu_a, alu_b, alu_control, metadata, illegal_op and stall_cnt.
- Transfer rules:
  - Capture occurs when in_valid & in_ready.
  - Downstream drain occurs when out_valid & out_ready.
- Hazard:
  - Per source, hz_s = ex_is_load & ex_reg_write & (ex_rd_addr != 0) & (ex_rd_addr == in_rsX_addr).
  - rs2 is checked only when in_use_imm = 0.
  - hazard = in_valid & (hz_rs1 | hz_rs2).
- in_ready = ~flush & ~hazard & (~out_valid | out_ready). Combinational; no dependence on in_valid except through hazard.
- State machine (registered, 2-bit), transitions evaluated after flush and reset:
  - EMPTY: out_valid=0.
    - Capture -> FULL.
    - in_valid & hazard -> LU_BUBBLE.
  - FULL: out_valid=1.
    - Drain without capture -> EMPTY.
    - Drain with capture -> FULL (back-to-back, new data).
    - No drain -> hold all registers.
  - LU_BUBBLE: out_valid=0, exactly one cycle. Load data is now on the WB path.
    - Next cycle -> EMPTY, or capture -> FULL.
- flush: next edge forces EMPTY and out_valid=0. No capture in a flush cycle. illegal_op and stall_cnt are unaffected.
- Operand forwarding per source, priority highest first:
  - rs addr == 0 -> 0.
  - ex_reg_write & ~ex_is_load & ex_rd_addr match -> ex_result.
  - wb_reg_write & wb_rd_addr match -> wb_data.
  - Otherwise register-file data.
- Operand assignment: alu_a = fwd(rs1). alu_b = in_use_imm ? in_imm : fwd(rs2).
- Illegal op: in_alu_control in {100, 110, 111} is captured as 000 (add) and sets illegal_op. illegal_op clears only on reset.
- stall_cnt: +1 each cycle with in_valid & hazard & ~flush; saturates at all-ones (no wrap).
- Latency: 1 cycle from capture to out_valid. Sustained throughput is 1/cycle when out_ready=1 and no hazard.
- Reset mid-operation: immediate return to EMPTY regardless of handshake state.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101).
  - stage_state_e enum (EMPTY, FULL, LU_BUBBLE).
  - Constant REG_ZERO = 0.
- Sub-module operand_fwd: combinational forwarding mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rstn low mid-FULL with alu_a=0x12345678 -> all outputs 0 asynchronously; in_ready=1 after release.
- Back-to-back: three instructions, out_ready=1, operands from regfile (rs1=0x5, rs2=0x3) -> out_valid continuous, alu_a=0x5, alu_b=0x3 each one cycle after capture.
- Forward priority: rs1=x7, EX writes x7=0xAAAA0000, WB writes x7=0x11111111 -> alu_a=0xAAAA0000; EX rd=x0 writing 0xFFFFFFFF, rs1=x0 -> alu_a=0.
- Load-use: EX is load to x4, incoming rs2=x4 -> in_ready=0 one cycle, LU_BUBBLE with out_valid=0, stall_cnt=1; next cycle WB supplies x4=0xBEEF -> alu_b=0xBEEF.
- Backpressure + flush: FULL with out_ready=0 for 3 cycles -> outputs stable; flush asserted -> out_valid=0 next edge, concurrent in_valid not captured.
- Illegal op: in_alu_control=111 -> alu_control=000, illegal_op=1, and it stays 1 after later legal ops until reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// Contains the ALU opcode encoding, the stage FSM encoding and the zero-register address.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        LU_BUBBLE = 2'd2
    } stage_state_e;

    localparam int unsigned REG_ZERO = 0;

    // True only for the five opcodes the ALU executes; 100, 110 and 111 are illegal.
    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: op_is_legal = 1'b1;
            default:                                    op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_fwd.sv
// Forwarding mux for one source operand.
// Priority: x0, then EX result (non-load), then WB data, then register file.
module operand_fwd
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs_addr,
    input  logic [N-1:0]    rf_data,
    input  logic [REGW-1:0] ex_rd_addr,
    input  logic            ex_reg_write,
    input  logic            ex_is_load,
    input  logic [N-1:0]    ex_result,
    input  logic [REGW-1:0] wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [N-1:0]    wb_data,
    output logic [N-1:0]    fwd_data
);

    always_comb begin
        // NOTE: the register-file value is assigned first so every path drives fwd_data and no latch is inferred.
        fwd_data = rf_data;
        if (rs_addr == REGW'(REG_ZERO)) begin
            fwd_data = '0;
        end else if (ex_reg_write && !ex_is_load && (ex_rd_addr == rs_addr)) begin
            fwd_data = ex_result;
        end else if (wb_reg_write && (wb_rd_addr == rs_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: captures decoded instructions, resolves forwarding and load-use hazards,
// and registers the ALU operands plus destination metadata for EX.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] in_rs1_addr,
    input  logic [REGW-1:0] in_rs2_addr,
    input  logic [N-1:0]    in_rs1_data,
    input  logic [N-1:0]    in_rs2_data,
    input  logic [N-1:0]    in_imm,
    input  logic            in_use_imm,
    input  logic [2:0]      in_alu_control,
    input  logic [REGW-1:0] in_rd_addr,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic            flush,
    input  logic [REGW-1:0] ex_rd_addr,
    input  logic            ex_reg_write,
    input  logic            ex_is_load,
    input  logic [N-1:0]    ex_result,
    input  logic [REGW-1:0] wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [N-1:0]    wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [2:0]      alu_control,
    output logic [REGW-1:0] out_rd_addr,
    output logic            out_reg_write,
    output logic            out_is_load,
    output logic            illegal_op,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [1:0] S_EMPTY     = EMPTY;
    localparam logic [1:0] S_FULL      = FULL;
    localparam logic [1:0] S_LU_BUBBLE = LU_BUBBLE;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    alu_a_q, alu_b_q;
    logic [2:0]      alu_control_q;
    logic [REGW-1:0] rd_addr_q;
    logic            reg_write_q, is_load_q, illegal_q;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic [N-1:0] fwd_rs1, fwd_rs2;
    logic         ex_load_pending, hz_rs1, hz_rs2, hazard;
    logic         capture, drain, op_legal;

    operand_fwd #(.N(N), .REGW(REGW)) u_fwd_rs1 (
        .rs_addr      (in_rs1_addr),
        .rf_data      (in_rs1_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .ex_result    (ex_result),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .fwd_data     (fwd_rs1)
    );

    operand_fwd #(.N(N), .REGW(REGW)) u_fwd_rs2 (
        .rs_addr      (in_rs2_addr),
        .rf_data      (in_rs2_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .ex_result    (ex_result),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .fwd_data     (fwd_rs2)
    );

    // A load in EX has no data yet, so a matching source must wait one cycle for WB.
    assign ex_load_pending = ex_is_load && ex_reg_write && (ex_rd_addr != REGW'(REG_ZERO));
    assign hz_rs1          = ex_load_pending && (ex_rd_addr == in_rs1_addr);
    assign hz_rs2          = ex_load_pending && (ex_rd_addr == in_rs2_addr) && !in_use_imm;
    assign hazard          = in_valid && (hz_rs1 || hz_rs2);

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !flush && !hazard && (!out_valid || out_ready);
    assign capture   = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign op_legal  = op_is_legal(in_alu_control);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (capture)     state_d = S_FULL;
                    else if (hazard) state_d = S_LU_BUBBLE;
                end
                S_FULL: begin
                    if (drain && !capture) state_d = S_EMPTY;
                end
                S_LU_BUBBLE: begin
                    state_d = capture ? S_FULL : S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: datapath registers are reset as well, so every output reads 0 straight out of reset.
        if (!rstn) begin
            state_q       <= S_EMPTY;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rd_addr_q     <= '0;
            reg_write_q   <= 1'b0;
            is_load_q     <= 1'b0;
            illegal_q     <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            if (capture) begin
                alu_a_q       <= fwd_rs1;
                alu_b_q       <= in_use_imm ? in_imm : fwd_rs2;
                alu_control_q <= op_legal ? in_alu_control : ALU_ADD;
                rd_addr_q     <= in_rd_addr;
                reg_write_q   <= in_reg_write;
                is_load_q     <= in_is_load;
                if (!op_legal) illegal_q <= 1'b1;
            end
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_control   = alu_control_q;
    assign out_rd_addr   = rd_addr_q;
    assign out_reg_write = reg_write_q;
    assign out_is_load   = is_load_q;
    assign illegal_op    = illegal_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; stall counter narrowed to 3 bits to reach saturation.
module tb_alu_issue_stage;

    localparam int TB_CNTW = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic in_valid, in_ready, in_use_imm, in_reg_write, in_is_load, flush;
    logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr, ex_rd_addr, wb_rd_addr, out_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, ex_result, wb_data, alu_a, alu_b;
    logic [2:0] in_alu_control, alu_control;
    logic ex_reg_write, ex_is_load, wb_reg_write;
    logic out_valid, out_ready, out_reg_write, out_is_load, illegal_op;
    logic [TB_CNTW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t exp_item;

    always #5 clk = ~clk;

    alu_issue_stage #(.N(32), .REGW(5), .CNTW(TB_CNTW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_control(in_alu_control),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .flush(flush),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_result(ex_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
        in_imm = '0; in_use_imm = 1'b0; in_alu_control = '0; in_rd_addr = '0;
        in_reg_write = 1'b0; in_is_load = 1'b0;
    endtask

    task automatic clear_bypass();
        ex_rd_addr = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_result = '0;
        wb_rd_addr = '0; wb_reg_write = 1'b0; wb_data = '0;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic use_imm,
                               input logic [2:0] ctl, input logic [4:0] rd,
                               input logic rw, input logic ld);
        in_valid = 1'b1; in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_use_imm = use_imm; in_alu_control = ctl; in_rd_addr = rd;
        in_reg_write = rw; in_is_load = ld;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive_idle(); clear_bypass();
        repeat (2) step();
        checks++;
        if ({out_valid, alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load,
             illegal_op, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_init: got valid=%b a=%h b=%h ctl=%b ill=%b cnt=%0d expected all zero",
                     out_valid, alu_a, alu_b, alu_control, illegal_op, stall_cnt);
        end
        rstn = 1'b1;
        step();
        drive_instr(5'd1, 5'd2, 32'h1234_5678, 32'h0, 32'h0000_0042, 1'b1, 3'b000, 5'd3, 1'b1, 1'b0);
        sb.push_back('{32'h1234_5678, 32'h0000_0042, 3'b000, 5'd3, 1'b1, 1'b0});
        step();
        drive_idle();
        exp_item = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 ||
            {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
            failures++;
            $display("FAIL reset_fill: got valid=%b a=%h b=%h expected valid=1 a=%h b=%h",
                     out_valid, alu_a, alu_b, exp_item.a, exp_item.b);
        end
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load,
             illegal_op, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_async: got valid=%b a=%h b=%h rd=%0d expected all zero",
                     out_valid, alu_a, alu_b, out_rd_addr);
        end
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ctls [3] = '{3'b000, 3'b001, 3'b011};
        for (int i = 0; i < 3; i++) begin
            drive_instr(5'd1, 5'd2, 32'h5, 32'h3, 32'h0, 1'b0, ctls[i], 5'(10 + i), 1'b1, 1'b0);
            sb.push_back('{32'h5, 32'h3, ctls[i], 5'(10 + i), 1'b1, 1'b0});
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            exp_item = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 ||
                {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
                failures++;
                $display("FAIL b2b_out[%0d]: got valid=%b a=%h b=%h ctl=%b rd=%0d expected a=%h b=%h ctl=%b rd=%0d",
                         i, out_valid, alu_a, alu_b, alu_control, out_rd_addr,
                         exp_item.a, exp_item.b, exp_item.ctl, exp_item.rd);
            end
        end
        drive_idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_forward_priority();
        for (int i = 0; i < 3; i++) begin
            clear_bypass();
            case (i)
                0: begin
                    ex_rd_addr = 5'd7; ex_reg_write = 1'b1; ex_result = 32'hAAAA_0000;
                    wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h1111_1111;
                    drive_instr(5'd7, 5'd0, 32'h7777, 32'h0, 32'h10, 1'b1, 3'b000, 5'd1, 1'b1, 1'b0);
                    sb.push_back('{32'hAAAA_0000, 32'h10, 3'b000, 5'd1, 1'b1, 1'b0});
                end
                1: begin
                    ex_rd_addr = 5'd0; ex_reg_write = 1'b1; ex_result = 32'hFFFF_FFFF;
                    wb_rd_addr = 5'd9; wb_reg_write = 1'b1; wb_data = 32'h99;
                    drive_instr(5'd0, 5'd9, 32'h1234, 32'h5555, 32'h0, 1'b0, 3'b010, 5'd2, 1'b1, 1'b0);
                    sb.push_back('{32'h0, 32'h99, 3'b010, 5'd2, 1'b1, 1'b0});
                end
                default: begin
                    wb_rd_addr = 5'd9; wb_reg_write = 1'b0; wb_data = 32'hDEAD;
                    drive_instr(5'd9, 5'd0, 32'h4242, 32'h0, 32'h0, 1'b1, 3'b101, 5'd3, 1'b0, 1'b1);
                    sb.push_back('{32'h4242, 32'h0, 3'b101, 5'd3, 1'b0, 1'b1});
                end
            endcase
            step();
            exp_item = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 ||
                {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
                failures++;
                $display("FAIL fwd[%0d]: got valid=%b a=%h b=%h expected a=%h b=%h",
                         i, out_valid, alu_a, alu_b, exp_item.a, exp_item.b);
            end
        end
        drive_idle(); clear_bypass();
        step();
    endtask

    task automatic test_load_use();
        ex_rd_addr = 5'd4; ex_reg_write = 1'b1; ex_is_load = 1'b1;
        drive_instr(5'd1, 5'd4, 32'h1, 32'hDEAD, 32'h0, 1'b0, 3'b000, 5'd5, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL lu_ready_low: got %b expected 0", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 3'd1) begin
            failures++;
            $display("FAIL lu_bubble: got out_valid=%b stall_cnt=%0d expected 0 1", out_valid, stall_cnt);
        end
        clear_bypass();
        wb_rd_addr = 5'd4; wb_reg_write = 1'b1; wb_data = 32'hBEEF;
        sb.push_back('{32'h1, 32'hBEEF, 3'b000, 5'd5, 1'b1, 1'b0});
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lu_ready_high: got %b expected 1", in_ready);
        end
        step();
        exp_item = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || stall_cnt !== 3'd1 ||
            {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
            failures++;
            $display("FAIL lu_wb_fwd: got valid=%b a=%h b=%h cnt=%0d expected a=%h b=%h cnt=1",
                     out_valid, alu_a, alu_b, stall_cnt, exp_item.a, exp_item.b);
        end
        // rs2 is ignored when the immediate is selected, so no hazard here.
        ex_rd_addr = 5'd4; ex_reg_write = 1'b1; ex_is_load = 1'b1;
        drive_instr(5'd1, 5'd4, 32'h2, 32'hDEAD, 32'h77, 1'b1, 3'b001, 5'd6, 1'b1, 1'b0);
        sb.push_back('{32'h2, 32'h77, 3'b001, 5'd6, 1'b1, 1'b0});
        step();
        exp_item = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || stall_cnt !== 3'd1 ||
            {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
            failures++;
            $display("FAIL lu_imm_no_hazard: got valid=%b a=%h b=%h cnt=%0d expected a=%h b=%h cnt=1",
                     out_valid, alu_a, alu_b, stall_cnt, exp_item.a, exp_item.b);
        end
        drive_idle(); clear_bypass();
        step();
    endtask

    task automatic test_backpressure_flush();
        out_ready = 1'b0;
        drive_instr(5'd2, 5'd0, 32'h1111, 32'h0, 32'h2222, 1'b1, 3'b010, 5'd6, 1'b1, 1'b0);
        sb.push_back('{32'h1111, 32'h2222, 3'b010, 5'd6, 1'b1, 1'b0});
        step();
        drive_instr(5'd3, 5'd0, 32'h3333, 32'h0, 32'h4444, 1'b1, 3'b011, 5'd7, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready: got %b expected 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 ||
                {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== sb[0]) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b a=%h b=%h expected a=%h b=%h",
                         i, out_valid, alu_a, alu_b, sb[0].a, sb[0].b);
            end
        end
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive_idle();
        void'(sb.pop_front());
        checks++;
        if (out_valid !== 1'b0 || alu_a !== 32'h1111) begin
            failures++;
            $display("FAIL flush: got out_valid=%b a=%h expected 0 00001111", out_valid, alu_a);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_capture: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_illegal_op();
        logic [2:0] ops     [3] = '{3'b111, 3'b001, 3'b100};
        logic [2:0] exp_ops [3] = '{3'b000, 3'b001, 3'b000};
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL ill_init: got %b expected 0", illegal_op);
        end
        for (int i = 0; i < 3; i++) begin
            drive_instr(5'd1, 5'd0, 32'h10, 32'h0, 32'h20, 1'b1, ops[i], 5'd8, 1'b1, 1'b0);
            sb.push_back('{32'h10, 32'h20, exp_ops[i], 5'd8, 1'b1, 1'b0});
            step();
            exp_item = sb.pop_front();
            checks++;
            if (illegal_op !== 1'b1 ||
                {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write, out_is_load} !== exp_item) begin
                failures++;
                $display("FAIL ill_op[%0d]: got ctl=%b ill=%b expected ctl=%b ill=1",
                         i, alu_control, illegal_op, exp_item.ctl);
            end
        end
        drive_idle();
        step();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (illegal_op !== 1'b0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL ill_reset: got ill=%b cnt=%0d expected 0 0", illegal_op, stall_cnt);
        end
        step();
        rstn = 1'b1;
    endtask

    task automatic test_stall_saturate();
        ex_rd_addr = 5'd4; ex_reg_write = 1'b1; ex_is_load = 1'b1;
        drive_instr(5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 5'd1, 1'b1, 1'b0);
        flush = 1'b1;
        repeat (2) step();
        checks++;
        if (stall_cnt !== 3'd0) begin
            failures++;
            $display("FAIL stall_flush: got %0d expected 0", stall_cnt);
        end
        flush = 1'b0;
        repeat (7) step();
        checks++;
        if (stall_cnt !== 3'd7) begin
            failures++;
            $display("FAIL stall_count: got %0d expected 7", stall_cnt);
        end
        repeat (3) step();
        checks++;
        if (stall_cnt !== 3'd7 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_saturate: got cnt=%0d valid=%b expected 7 0", stall_cnt, out_valid);
        end
        drive_idle(); clear_bypass();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_forward_priority();
        test_load_use();
        test_backpressure_flush();
        test_illegal_op();
        test_stall_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
